// File: rtl/gtech_reduce_pipe.sv
// Pipelined WIDTH-bit reduction (AND/OR/XOR with optional final inversion).
// A balanced tree of 2-input gates, registered per level (PIPE=1) or once at the output (PIPE=0).
module gtech_reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             VI,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    output logic             VO,
    output logic             Z,
    output logic             ERR
);
    localparam int D  = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int P  = 1 << D;
    localparam int NS = (PIPE != 0 && D > 1) ? D : 1;

    // The reserved encoding falls through to AND.
    function automatic logic combine(input logic [1:0] op, input logic x, input logic y);
        case (op)
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return x & y;
        endcase
    endfunction

    logic [P-1:0] a_pad;

    for (genvar gi = 0; gi < P; gi++) begin : g_pad
        if (gi < WIDTH) begin : g_bit
            assign a_pad[gi] = A[gi];
        end else begin : g_fill
            assign a_pad[gi] = ~((OP[1:0] == 2'b01) || (OP[1:0] == 2'b10));
        end
    end

    for (genvar gi = 1; gi <= NS; gi++) begin : g_stage
        localparam int WI = P >> (gi - 1);
        localparam int WO = (PIPE != 0 && (P >> gi) > 0) ? (P >> gi) : 1;

        logic               vld_in;
        logic               vld_q;
        logic [2:0]         op_in;
        logic [2:0]         op_q;
        logic [WI-1:0]      dat_in;
        logic [WO-1:0]      dat_d;
        logic [WO-1:0]      dat_q;
        logic [2*WI-2:WO-1] node;

        if (gi == 1) begin : g_src
            assign vld_in = VI;
            assign op_in  = OP;
            assign dat_in = a_pad;
        end else begin : g_chain
            assign vld_in = g_stage[gi-1].vld_q;
            assign op_in  = g_stage[gi-1].op_q;
            assign dat_in = g_stage[gi-1].dat_q;
        end

        // Heap-ordered partial tree: leaves at WI-1.., this stage's outputs at WO-1..
        always_comb begin
            node = '0;
            for (int k = 0; k < WI; k++) begin
                node[WI-1+k] = dat_in[k];
            end
            for (int k = WI - 2; k >= WO - 1; k--) begin
                node[k] = combine(op_in[1:0], node[2*k+1], node[2*k+2]);
            end
            dat_d = node[2*WO-2:WO-1];
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                vld_q <= 1'b0;
                op_q  <= 3'b000;
                dat_q <= '0;
            end else if (EN) begin
                vld_q <= vld_in;
                op_q  <= op_in;
                dat_q <= dat_d;
            end
        end
    end

    // Inversion and qualification happen once, after the last register.
    assign VO  = g_stage[NS].vld_q;
    assign Z   = g_stage[NS].vld_q & (g_stage[NS].dat_q[0] ^ g_stage[NS].op_q[2]);
    assign ERR = g_stage[NS].vld_q & (g_stage[NS].op_q[1:0] == 2'b11);
endmodule
